// File: rtl/phase_sweep_nco.sv
// phase_sweep_nco: phase-accumulator NCO with optional linear tuning-word sweep
module phase_sweep_nco #(
  parameter int ACC_W   = 32,
  parameter int OUT_W   = 16,
  parameter int DWELL_W = 16
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_cfg_valid,
  output logic               o_cfg_ready,
  input  logic [ACC_W-1:0]   i_ftw_start,
  input  logic [ACC_W-1:0]   i_ftw_step,
  input  logic [ACC_W-1:0]   i_ftw_end,
  input  logic [DWELL_W-1:0] i_dwell,
  input  logic [OUT_W-1:0]   i_phase_ofs,
  input  logic [1:0]         i_mode,
  input  logic               i_start,
  input  logic               i_stop,
  output logic [OUT_W-1:0]   o_addr,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t               state_q, state_d;
  logic [ACC_W-1:0]     acc_q, acc_d, ftw_q, ftw_d;
  logic [ACC_W-1:0]     start_q, step_q, end_q;
  logic [DWELL_W-1:0]   dwell_q, dcnt_q, dcnt_d;
  logic [OUT_W-1:0]     ofs_q, addr_q, addr_d;
  logic [1:0]           mode_q;
  logic                 term_q, term_d, valid_q, valid_d, done_q, done_d;
  logic [ACC_W:0]       sum;
  logic [DWELL_W:0]     dnext;
  logic                 period_end, start_ge_end, cfg_fire;
  assign o_cfg_ready  = (state_q == IDLE);
  assign o_busy       = (state_q == RUN);
  assign o_addr       = addr_q;
  assign o_valid      = valid_q;
  assign o_done       = done_q;
  assign cfg_fire     = i_cfg_valid & (state_q == IDLE);
  assign sum          = {1'b0, ftw_q} + {1'b0, step_q};
  assign dnext        = {1'b0, dcnt_q} + {{DWELL_W{1'b0}}, 1'b1};
  assign period_end   = dnext >= {1'b0, dwell_q};
  assign start_ge_end = start_q >= end_q;
  // Next-state: term_q marks that ftw has reached the end word and the current dwell period is the last
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ftw_d   = ftw_q;
    dcnt_d  = dcnt_q;
    term_d  = term_q;
    addr_d  = addr_q;
    valid_d = 1'b0;
    done_d  = 1'b0;
    if (state_q == IDLE) begin
      if (i_start) begin
        state_d = RUN;
        acc_d   = '0;
        ftw_d   = start_q;
        dcnt_d  = '0;
        term_d  = mode_q[0] & start_ge_end;
      end
    end else if (i_stop) begin
      state_d = IDLE;
    end else begin
      addr_d  = acc_q[ACC_W-1 -: OUT_W] + ofs_q;
      valid_d = 1'b1;
      acc_d   = acc_q + ftw_q;
      if (mode_q[0]) begin
        dcnt_d = period_end ? '0 : dnext[DWELL_W-1:0];
        if (period_end) begin
          if (term_q) begin
            if (mode_q[1]) begin
              ftw_d  = start_q;
              term_d = start_ge_end;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else if (sum >= {1'b0, end_q}) begin
            ftw_d  = end_q;
            term_d = 1'b1;
          end else begin
            ftw_d = sum[ACC_W-1:0];
          end
        end
      end
    end
  end
  // State, datapath and shadow configuration registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ftw_q   <= '0;
      dcnt_q  <= '0;
      term_q  <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      start_q <= '0;
      step_q  <= '0;
      end_q   <= '0;
      dwell_q <= '0;
      ofs_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ftw_q   <= ftw_d;
      dcnt_q  <= dcnt_d;
      term_q  <= term_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      if (cfg_fire) begin
        start_q <= i_ftw_start;
        step_q  <= i_ftw_step;
        end_q   <= i_ftw_end;
        dwell_q <= i_dwell;
        ofs_q   <= i_phase_ofs;
        mode_q  <= i_mode;
      end
    end
  end
endmodule

// File: tb/tb_phase_sweep_nco.sv
// tb_phase_sweep_nco: randomized and directed checks of phase_sweep_nco against a sample-sequence model
module tb_phase_sweep_nco;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cfg_valid = 1'b0, cfg_ready;
  logic [31:0] ftw_start = '0, ftw_step = '0, ftw_end = '0;
  logic [15:0] dwell = '0, phase_ofs = '0;
  logic [1:0]  mode = '0;
  logic        start = 1'b0, stop = 1'b0;
  logic [15:0] addr;
  logic        valid, busy, done;
  int          nchk = 0, nerr = 0;
  logic [31:0] segs[$];

  phase_sweep_nco dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_ftw_start(ftw_start), .i_ftw_step(ftw_step), .i_ftw_end(ftw_end), .i_dwell(dwell),
    .i_phase_ofs(phase_ofs), .i_mode(mode), .i_start(start), .i_stop(stop),
    .o_addr(addr), .o_valid(valid), .o_busy(busy), .o_done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // List of tuning words held for one dwell period each, in sweep order
  task automatic build_segs(input logic [31:0] fs, input logic [31:0] st, input logic [31:0] fe);
    logic [32:0] nf;
    logic [31:0] f;
    segs.delete();
    segs.push_back(fs);
    if (fs < fe) begin
      f = fs;
      forever begin
        nf = {1'b0, f} + {1'b0, st};
        if (nf >= {1'b0, fe}) begin
          segs.push_back(fe);
          break;
        end
        f = nf[31:0];
        segs.push_back(f);
      end
    end
  endtask

  task automatic run(input logic [31:0] fs, input logic [31:0] st, input logic [31:0] fe,
                     input logic [15:0] dw, input logic [15:0] ofs, input logic [1:0] md,
                     input int nmax, input bit stop_at_end, input bit do_cfg, input bit inject);
    int          period, total, idx;
    logic [31:0] acc, f;
    logic [15:0] ea;
    bit          last;
    if (do_cfg) begin
      ftw_start = fs; ftw_step = st; ftw_end = fe; dwell = dw; phase_ofs = ofs; mode = md;
      cfg_valid = 1'b1;
      @(negedge clk);
      cfg_valid = 1'b0;
    end
    chk("idle_ready", cfg_ready, 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run_busy", busy, 1);
    chk("run_ready", cfg_ready, 0);
    build_segs(fs, st, fe);
    period = (dw == 0) ? 1 : int'(dw);
    total = (md == 2'd1) ? segs.size() * period : nmax;
    acc = '0;
    for (int c = 0; c < total; c++) begin
      last = (md == 2'd1) && (c == total - 1);
      if (last && stop_at_end) begin
        stop = 1'b1;
        @(negedge clk);
        stop = 1'b0;
        chk("stop_term_valid", valid, 0);
        chk("stop_term_done", done, 0);
        chk("stop_term_busy", busy, 0);
        return;
      end
      if (inject && c == 3) begin
        ftw_start = ~fs; ftw_step = ~st; ftw_end = ~fe; dwell = ~dw; phase_ofs = ~ofs; mode = ~md;
        cfg_valid = 1'b1;
        chk("cfg_ready_in_run", cfg_ready, 0);
      end
      @(negedge clk);
      cfg_valid = 1'b0;
      ea = acc[31:16] + ofs;
      chk("addr", addr, ea);
      chk("valid", valid, 1);
      chk("done", done, last);
      chk("busy", busy, !last);
      idx = c / period;
      if (md[0]) idx = idx % segs.size();
      f = md[0] ? segs[idx] : fs;
      acc = acc + f;
    end
    if (md != 2'd1) begin
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("stop_valid", valid, 0);
      chk("stop_busy", busy, 0);
      chk("stop_done", done, 0);
    end else begin
      @(negedge clk);
      chk("end_valid", valid, 0);
      chk("end_done", done, 0);
      chk("end_busy", busy, 0);
    end
    chk("hold_addr", addr, ea);
    chk("end_ready", cfg_ready, 1);
  endtask

  initial begin
    logic [31:0] fs, fe, st;
    logic [1:0]  md;
    #1;
    chk("rst_addr", addr, 0);
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", cfg_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    chk("idle_stop_ignored", cfg_ready, 1);
    run(32'h0100_0000, 0, 0, 0, 16'h0000, 2'd0, 260, 0, 1, 0);
    run(32'h8000_0000, 0, 0, 0, 16'hC000, 2'd0, 8, 0, 1, 0);
    run(32'h0001_0000, 32'h0001_0000, 32'h0003_0000, 2, 0, 2'd1, 0, 0, 1, 0);
    run(32'h0001_0000, 32'h0001_0000, 32'h0003_0000, 2, 0, 2'd3, 30, 0, 1, 0);
    run(32'h0001_0000, 32'h0001_0000, 32'h0003_0000, 2, 0, 2'd1, 0, 1, 1, 0);
    run(32'h0005_0000, 32'h0001_0000, 32'h0003_0000, 3, 16'h1234, 2'd1, 0, 0, 1, 0);
    run(32'h0001_0000, 32'h0002_0000, 32'h0004_0000, 0, 16'h0010, 2'd1, 0, 0, 1, 0);
    run(32'h1234_5678, 0, 0, 0, 16'h00AA, 2'd0, 12, 0, 1, 1);
    run(32'h1234_5678, 0, 0, 0, 16'h00AA, 2'd0, 12, 0, 0, 0);
    for (int n = 0; n < 16; n++) begin
      fs = $urandom;
      fe = $urandom;
      st = (fs < fe) ? (fe - fs) / $urandom_range(1, 6) + $urandom_range(1, 1000) : $urandom;
      md = 2'($urandom_range(0, 3));
      run(fs, st, fe, 16'($urandom_range(0, 4)), 16'($urandom), md, 40, 0, 1, 0);
    end
    ftw_start = 32'h0001_0000; ftw_step = 32'h0001_0000; ftw_end = 32'h0003_0000;
    dwell = 16'd3; phase_ofs = 16'h5555; mode = 2'd1;
    cfg_valid = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_addr", addr, 0);
    chk("arst_valid", valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_ready", cfg_ready, 1);
    @(negedge clk);
    chk("arst_no_done", done, 0);
    rst_n = 1'b1;
    run(0, 0, 0, 0, 0, 2'd0, 10, 0, 0, 0);
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
